// File: rtl/ysyx_22041071_mem_stage_pkg.sv
// Shared constants, FSM states and the WB-entry record for the MEM stage.
package ysyx_22041071_mem_stage_pkg;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned INS_W  = 32;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  // funct3 access-size codes; bit 2 selects zero-extension for loads
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_D  = 3'd3;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;
  localparam logic [2:0] F3_WU = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_HOLD   = 2'd2
  } mem_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INS_W-1:0]  ins;
    logic              reg_w_en;
    logic [4:0]        rdest;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      2'd0:    return 8'h01;
      2'd1:    return 8'h03;
      2'd2:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return off[0];
      2'd2:    return |off[1:0];
      default: return |off;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_22041071_mem_stage_if.sv
// Data-memory req/ack bus between the MEM stage (master) and memory (slave).
interface ysyx_22041071_mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic [7:0]  dmem_wmask;
  logic        dmem_ack;
  logic [63:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wmask,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wmask,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/ysyx_22041071_mem_stage_lsu_align.sv
// Combinational lane logic: store mask/data shift into the doubleword, load extract + extend.
module ysyx_22041071_lsu_align
  import ysyx_22041071_mem_stage_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [2:0]  offset_i,
  input  logic [63:0] store_data_i,
  input  logic [63:0] rdata_i,
  output logic [7:0]  wmask_o,
  output logic [63:0] wdata_o,
  output logic [63:0] load_data_o
);

  logic [63:0] shifted;

  always_comb begin
    // bytes pushed past lane 7 simply fall off the 8-bit mask / 64-bit data
    wmask_o = size_mask(funct3_i[1:0]) << offset_i;
    wdata_o = store_data_i << {offset_i, 3'b000};
    shifted = rdata_i >> {offset_i, 3'b000};
    case (funct3_i)
      F3_B:    load_data_o = {{56{shifted[7]}},  shifted[7:0]};
      F3_H:    load_data_o = {{48{shifted[15]}}, shifted[15:0]};
      F3_W:    load_data_o = {{32{shifted[31]}}, shifted[31:0]};
      F3_BU:   load_data_o = {56'd0, shifted[7:0]};
      F3_HU:   load_data_o = {48'd0, shifted[15:0]};
      F3_WU:   load_data_o = {32'd0, shifted[31:0]};
      default: load_data_o = shifted;
    endcase
  end

endmodule

// File: rtl/ysyx_22041071_mem_stage.sv
// MEM pipeline stage: EX->MEM (valid5/ready5), dmem req/ack bus, MEM->WB register (valid6/ready6).
// Optional YSYX_22041071_MISALIGN_TRAP_EN adds mem_misalign and suppresses misaligned accesses.
module ysyx_22041071_mem_stage
  import ysyx_22041071_mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        valid5,
  output logic        ready5,
  input  logic [63:0] PC5,
  input  logic [31:0] Ins4,
  input  logic        MEM_W_en3,
  input  logic        WB_sel3,
  input  logic        reg_w_en3,
  input  logic [4:0]  rdest2,
  input  logic [63:0] rt_data2,
  input  logic [63:0] ALU_result1,
  ysyx_22041071_mem_stage_if.master dmem,
  output logic        valid6,
  input  logic        ready6,
  output logic [63:0] PC6,
  output logic [31:0] Ins5,
  output logic        reg_w_en6,
  output logic [4:0]  rdest6,
  output logic [63:0] WB_data
`ifdef YSYX_22041071_MISALIGN_TRAP_EN
  ,
  output logic        mem_misalign
`endif
);

  mem_state_e  state_q, state_d;

  // request captured on IDLE->ACCESS so the bus stays stable for the whole access
  logic [63:0] req_addr_q;
  logic        req_we_q;
  logic [2:0]  req_f3_q;
  logic [63:0] req_sdata_q;
  logic [63:0] hold_q;

  wb_entry_t   out_q, out_d;
  logic        valid6_q;

  logic        mem_op, slot_free, in_access;
  logic        req_latch, hold_we;
  logic [7:0]  al_wmask;
  logic [63:0] al_wdata, al_load, sel_data;

`ifdef YSYX_22041071_MISALIGN_TRAP_EN
  logic        mis_q, mis_d;
`endif

  ysyx_22041071_lsu_align u_align (
    .funct3_i     (req_f3_q),
    .offset_i     (req_addr_q[2:0]),
    .store_data_i (req_sdata_q),
    .rdata_i      (dmem.dmem_rdata),
    .wmask_o      (al_wmask),
    .wdata_o      (al_wdata),
    .load_data_o  (al_load)
  );

  always_comb begin
    mem_op    = valid5 & ((Ins4[6:0] == OPC_LOAD) | MEM_W_en3);
    slot_free = ~valid6_q | ready6;
    sel_data  = WB_sel3 ? al_load : ALU_result1;

    state_d   = state_q;
    ready5    = 1'b0;
    req_latch = 1'b0;
    hold_we   = 1'b0;
    out_d     = '{pc: PC5, ins: Ins4, reg_w_en: reg_w_en3, rdest: rdest2, data: sel_data};
`ifdef YSYX_22041071_MISALIGN_TRAP_EN
    mis_d     = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (valid5 && slot_free) begin
          if (!mem_op) begin
            ready5     = 1'b1;
            out_d.data = ALU_result1;
          end else begin
`ifdef YSYX_22041071_MISALIGN_TRAP_EN
            if (is_misaligned(Ins4[13:12], ALU_result1[2:0])) begin
              ready5         = 1'b1;
              out_d.data     = '0;
              out_d.reg_w_en = 1'b0;
              mis_d          = 1'b1;
            end else begin
              req_latch = 1'b1;
              state_d   = ST_ACCESS;
            end
`else
            req_latch = 1'b1;
            state_d   = ST_ACCESS;
`endif
          end
        end
      end
      ST_ACCESS: begin
        if (dmem.dmem_ack) begin
          if (slot_free) begin
            ready5  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            hold_we = 1'b1;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (slot_free) begin
          ready5     = 1'b1;
          out_d.data = hold_q;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_access       = (state_q == ST_ACCESS);
    dmem.dmem_req   = in_access;
    dmem.dmem_we    = in_access & req_we_q;
    dmem.dmem_addr  = in_access ? req_addr_q : '0;
    dmem.dmem_wmask = (in_access && req_we_q) ? al_wmask : '0;
    dmem.dmem_wdata = (in_access && req_we_q) ? al_wdata : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      req_addr_q  <= '0;
      req_we_q    <= 1'b0;
      req_f3_q    <= '0;
      req_sdata_q <= '0;
      hold_q      <= '0;
      out_q       <= '0;
      valid6_q    <= 1'b0;
`ifdef YSYX_22041071_MISALIGN_TRAP_EN
      mis_q       <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (req_latch) begin
        req_addr_q  <= ALU_result1;
        req_we_q    <= MEM_W_en3;
        req_f3_q    <= Ins4[14:12];
        req_sdata_q <= rt_data2;
      end
      if (hold_we) hold_q <= sel_data;
      // a drain and a new acceptance in the same cycle simply overwrite the slot
      if (ready5) begin
        out_q    <= out_d;
        valid6_q <= 1'b1;
`ifdef YSYX_22041071_MISALIGN_TRAP_EN
        mis_q    <= mis_d;
`endif
      end else if (ready6) begin
        valid6_q <= 1'b0;
      end
    end
  end

  always_comb begin
    valid6    = valid6_q;
    PC6       = out_q.pc;
    Ins5      = out_q.ins;
    reg_w_en6 = out_q.reg_w_en;
    rdest6    = out_q.rdest;
    WB_data   = out_q.data;
`ifdef YSYX_22041071_MISALIGN_TRAP_EN
    mem_misalign = mis_q;
`endif
  end

endmodule

// File: tb/tb_ysyx_22041071_mem_stage.sv
// Randomized bench for the MEM stage against a byte-array memory and program-order reference model.
module tb_ysyx_22041071_mem_stage;

`ifdef YSYX_22041071_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        valid5, ready5;
  logic [63:0] PC5, rt_data2, ALU_result1;
  logic [31:0] Ins4;
  logic        MEM_W_en3, WB_sel3, reg_w_en3;
  logic [4:0]  rdest2;
  logic        valid6, ready6;
  logic [63:0] PC6, WB_data;
  logic [31:0] Ins5;
  logic        reg_w_en6;
  logic [4:0]  rdest6;
`ifdef YSYX_22041071_MISALIGN_TRAP_EN
  logic        mem_misalign;
`endif

  always #5 clk = ~clk;

  ysyx_22041071_mem_stage_if dmem ();

  ysyx_22041071_mem_stage dut (
    .clk(clk), .reset(reset),
    .valid5(valid5), .ready5(ready5), .PC5(PC5), .Ins4(Ins4),
    .MEM_W_en3(MEM_W_en3), .WB_sel3(WB_sel3), .reg_w_en3(reg_w_en3),
    .rdest2(rdest2), .rt_data2(rt_data2), .ALU_result1(ALU_result1),
    .dmem(dmem),
    .valid6(valid6), .ready6(ready6), .PC6(PC6), .Ins5(Ins5),
    .reg_w_en6(reg_w_en6), .rdest6(rdest6), .WB_data(WB_data)
`ifdef YSYX_22041071_MISALIGN_TRAP_EN
    , .mem_misalign(mem_misalign)
`endif
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
    logic        mem_w, wb_sel, regw;
    logic [4:0]  rdest;
    logic [63:0] rt, alu;
  } ex_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
    logic        regw;
    logic [4:0]  rdest;
    logic [63:0] data;
    logic        mis;
  } wb_t;

  int unsigned n_checks = 0, n_errors = 0;
  wb_t  sb_q[$];
  ex_t  dir_q[$];
  logic [7:0] ref_mem[128];
  logic [7:0] bus_mem[128];
  ex_t  cur;
  bit   cur_valid = 0, acked = 0, req_active = 0;
  int   wait_cnt = 0, req_count = 0, exp_reqs = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_load(input ex_t e);
    return e.ins[6:0] == 7'b0000011;
  endfunction

  function automatic bit is_mem(input ex_t e);
    return is_load(e) || e.mem_w;
  endfunction

  function automatic int nbytes(input ex_t e);
    return 1 << int'(e.ins[13:12]);
  endfunction

  function automatic bit misal(input ex_t e);
    bit m = is_mem(e) && ((int'(e.alu[2:0]) % nbytes(e)) != 0);
    return TRAP_EN && m;
  endfunction

  function automatic logic [63:0] model_load(input ex_t e);
    int n = nbytes(e);
    int off = int'(e.alu[2:0]);
    int base = int'(e.alu[6:0]) - off;
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++)
      if (off + i < 8) v[8*i +: 8] = ref_mem[base + off + i];
    if (!e.ins[14] && n < 8 && v[8*n-1])
      for (int b = 8*n; b < 64; b++) v[b] = 1'b1;
    return v;
  endfunction

  function automatic logic [7:0] model_mask(input ex_t e);
    logic [7:0] m = '0;
    int off = int'(e.alu[2:0]);
    for (int i = 0; i < nbytes(e); i++)
      if (off + i < 8) m[off + i] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] model_wdata(input ex_t e);
    logic [63:0] w = '0;
    int off = int'(e.alu[2:0]);
    for (int i = 0; i < nbytes(e); i++)
      if (off + i < 8) w[8*(off+i) +: 8] = e.rt[8*i +: 8];
    return w;
  endfunction

  function automatic logic [63:0] lanes(input logic [7:0] m);
    logic [63:0] l;
    for (int j = 0; j < 8; j++) l[8*j +: 8] = {8{m[j]}};
    return l;
  endfunction

  task automatic model_store(input ex_t e);
    int off = int'(e.alu[2:0]);
    int base = int'(e.alu[6:0]) - off;
    for (int i = 0; i < nbytes(e); i++)
      if (off + i < 8) ref_mem[base + off + i] = e.rt[8*i +: 8];
  endtask

  function automatic ex_t make_entry(input int kind, input logic [2:0] f3, input logic [63:0] addr,
                                     input logic [63:0] rt);
    ex_t e;
    e.pc = {$urandom(), $urandom()};
    e.ins = $urandom();
    e.rdest = 5'($urandom_range(0, 31));
    e.rt = rt;
    e.alu = addr;
    e.ins[14:12] = f3;
    case (kind)
      0: begin e.ins[6:0] = 7'b0110011; e.mem_w = 0; e.wb_sel = 0; e.regw = 1; end
      1: begin e.ins[6:0] = 7'b0000011; e.mem_w = 0; e.wb_sel = 1; e.regw = 1; end
      default: begin e.ins[6:0] = 7'b0100011; e.mem_w = 1; e.wb_sel = 0; e.regw = 0; end
    endcase
    return e;
  endfunction

  function automatic ex_t gen_entry();
    int kind = $urandom_range(0, 2);
    logic [63:0] addr = 64'h8000_0000 + 64'($urandom_range(0, 127));
    case (kind)
      0: return make_entry(0, 3'($urandom_range(0, 7)), {$urandom(), $urandom()}, {$urandom(), $urandom()});
      1: return make_entry(1, 3'($urandom_range(0, 6)), addr, {$urandom(), $urandom()});
      default: return make_entry(2, 3'($urandom_range(0, 3)), addr, {$urandom(), $urandom()});
    endcase
  endfunction

  task automatic drive_cur();
    valid5 = cur_valid; PC5 = cur.pc; Ins4 = cur.ins; MEM_W_en3 = cur.mem_w;
    WB_sel3 = cur.wb_sel; reg_w_en3 = cur.regw; rdest2 = cur.rdest;
    rt_data2 = cur.rt; ALU_result1 = cur.alu;
  endtask

  task automatic cycle(input bit allow_new, input int ready6_pct);
    wb_t w;
    bit slot_free, exp_r5;
    int base;
    @(negedge clk);
    if (!cur_valid && allow_new) begin
      if (dir_q.size() > 0) begin
        cur = dir_q.pop_front(); cur_valid = 1; acked = 0;
      end else if ($urandom_range(0, 3) != 0) begin
        cur = gen_entry(); cur_valid = 1; acked = 0;
      end
    end
    drive_cur();
    ready6 = ($urandom_range(0, 99) < ready6_pct);
    dmem.dmem_ack = 1'b0;
    if (dmem.dmem_req) begin
      if (!req_active) begin
        req_active = 1; req_count++; wait_cnt = $urandom_range(0, 3);
        check_eq("req_addr", dmem.dmem_addr, cur.alu);
        check_eq("req_we", 64'(dmem.dmem_we), 64'(cur.mem_w));
        if (cur.mem_w) begin
          check_eq("wmask", 64'(dmem.dmem_wmask), 64'(model_mask(cur)));
          check_eq("wdata", dmem.dmem_wdata & lanes(model_mask(cur)), model_wdata(cur));
        end
      end else begin
        check_eq("req_addr_stable", dmem.dmem_addr, cur.alu);
      end
      if (wait_cnt == 0) begin
        base = int'(dmem.dmem_addr[6:3]) * 8;
        for (int j = 0; j < 8; j++) begin
          dmem.dmem_rdata[8*j +: 8] = bus_mem[base + j];
          if (dmem.dmem_wmask[j]) bus_mem[base + j] = dmem.dmem_wdata[8*j +: 8];
        end
        dmem.dmem_ack = 1'b1; req_active = 0; acked = 1;
      end else begin
        wait_cnt--;
      end
    end
    #1;
    slot_free = !valid6 || ready6;
    exp_r5 = cur_valid && ((is_mem(cur) && !misal(cur)) ? (acked && slot_free) : slot_free);
    check_eq("ready5", 64'(ready5), 64'(exp_r5));
    if (valid6 && ready6) begin
      if (sb_q.size() == 0) begin
        check_eq("valid6_spurious", 64'(valid6), 64'd0);
      end else begin
        w = sb_q.pop_front();
        check_eq("PC6", PC6, w.pc);
        check_eq("Ins5", 64'(Ins5), 64'(w.ins));
        check_eq("reg_w_en6", 64'(reg_w_en6), 64'(w.regw));
        check_eq("rdest6", 64'(rdest6), 64'(w.rdest));
        check_eq("WB_data", WB_data, w.data);
`ifdef YSYX_22041071_MISALIGN_TRAP_EN
        check_eq("mem_misalign", 64'(mem_misalign), 64'(w.mis));
`endif
      end
    end
    if (ready5 && cur_valid) begin
      w.pc = cur.pc; w.ins = cur.ins; w.rdest = cur.rdest; w.mis = misal(cur);
      w.regw = w.mis ? 1'b0 : cur.regw;
      w.data = w.mis ? 64'd0 : ((is_mem(cur) && cur.wb_sel) ? model_load(cur) : cur.alu);
      sb_q.push_back(w);
      if (is_mem(cur) && !w.mis) exp_reqs++;
      if (cur.mem_w && !w.mis) model_store(cur);
      cur_valid = 0;
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      ref_mem[i] = 8'($urandom());
      bus_mem[i] = ref_mem[i];
    end
    reset = 1; ready6 = 0; dmem.dmem_ack = 0; dmem.dmem_rdata = '0;
    cur = make_entry(0, 3'd0, 64'd0, 64'd0);
    drive_cur();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_valid6", 64'(valid6), 64'd0);
    check_eq("rst_dmem_req", 64'(dmem.dmem_req), 64'd0);
    check_eq("rst_WB_data", WB_data, 64'd0);
    check_eq("rst_PC6", PC6, 64'd0);
    check_eq("rst_reg_w_en6", 64'(reg_w_en6), 64'd0);
    check_eq("rst_wmask", 64'(dmem.dmem_wmask), 64'd0);
    reset = 0;

    // reset while a load is waiting for its ack
    @(negedge clk);
    cur = make_entry(1, 3'd3, 64'h8000_0010, 64'd0);
    cur_valid = 1; drive_cur(); ready6 = 1;
    @(negedge clk);
    check_eq("pre_rst_req", 64'(dmem.dmem_req), 64'd1);
    reset = 1; valid5 = 0; cur_valid = 0;
    @(negedge clk);
    check_eq("post_rst_req", 64'(dmem.dmem_req), 64'd0);
    check_eq("post_rst_valid6", 64'(valid6), 64'd0);
    reset = 0;
    req_count = 0;

    // directed: ALU pass-through, sb at offset 3, lh/lhu at offset 6, misaligned lw
    ref_mem[7'h16] = 8'h01; bus_mem[7'h16] = 8'h01;
    ref_mem[7'h17] = 8'h80; bus_mem[7'h17] = 8'h80;
    dir_q.push_back(make_entry(0, 3'd0, 64'h1234, 64'd0));
    dir_q.push_back(make_entry(2, 3'd0, 64'h8000_0003, 64'hAB));
    dir_q.push_back(make_entry(1, 3'd1, 64'h8000_0016, 64'd0));
    dir_q.push_back(make_entry(1, 3'd5, 64'h8000_0016, 64'd0));
    dir_q.push_back(make_entry(1, 3'd2, 64'h8000_0002, 64'd0));
    dir_q.push_back(make_entry(1, 3'd3, 64'h8000_0010, 64'd0));
    repeat (40) cycle(1, 100);
    repeat (400) cycle(1, 30);
    repeat (1200) cycle(1, 70);
    repeat (40) cycle(0, 100);

    check_eq("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    check_eq("ex_entry_consumed", 64'(cur_valid), 64'd0);
    check_eq("req_count", 64'(req_count), 64'(exp_reqs));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
